cache_mem_arbiter: RTL
======================

CACHE_MEM_ARBITER -- requirements
Module: cache_mem_arbiter

Interface
REQ-001 Parameter MEM_LATENCY, default 4: cycles from a memory read issue (mem_en=1, mem_wr=0) to its mem_valid.
REQ-002 Parameter LINE_WORDS, default 8: 16-bit words per cache line; fixed at 8 for this revision.
REQ-003 clk  in  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  in  1  reset, synchronous and active-low.
REQ-005 i_req / i_addr  in  1/16  instruction-cache miss request and miss address; held until i_done.
REQ-006 d_req / d_addr  in  1/16  data-cache miss request and miss address; held until d_done.
REQ-007 wt_req / wt_addr / wt_data  in  1/16/16  data-cache store write-through request; held until wt_ack.
REQ-008 mem_en, mem_wr, mem_addr, mem_wdata  out  1/1/16/16  single shared memory port.
REQ-009 mem_valid / mem_rdata  in  1/16  memory read return.
REQ-010 fill_we, fill_sel, fill_word, fill_data  out  1/1/3/16  cache line-fill word write; fill_sel 0 = I-cache, 1 = D-cache.
REQ-011 fill_tag_we  out  1  one-cycle tag/valid write for the line just filled, with fill_sel valid.
REQ-012 i_done, d_done, wt_ack  out  1  one-cycle completion pulses.
REQ-013 i_busy, d_busy  out  1  combinational stall outputs for the fetch and memory stages.

Function
REQ-014 The block SHALL have these states: IDLE, ISSUE, WAIT, DONE and WRITE.
REQ-015 Arbitration in IDLE SHALL use fixed priority i_req > wt_req > d_req.
REQ-016 Anti-starvation: d_req SHALL win over i_req and wt_req when d_req was already pending at the start of the preceding grant.
REQ-017 When a fill is granted, the block SHALL latch base = addr & 16'hFFF0 and fill_sel, then move to ISSUE the next cycle.
REQ-018 ISSUE SHALL last exactly 8 cycles, with mem_en=1, mem_wr=0 and mem_addr = base + 2*issue_cnt for issue_cnt 0..7, then move to WAIT.
REQ-019 In ISSUE and WAIT, each mem_valid SHALL produce fill_we=1 in the same cycle, with fill_data=mem_rdata and fill_word=ret_cnt; ret_cnt (0..7) then increments.
REQ-020 The state SHALL move to DONE in the cycle after the 8th return, whether that return arrives in ISSUE or WAIT.
REQ-021 DONE SHALL last one cycle, asserting fill_tag_we=1 and i_done or d_done per fill_sel, then return to IDLE.
REQ-022 A write-through grant SHALL move to WRITE for one cycle: mem_en=1, mem_wr=1, mem_addr=wt_addr, mem_wdata=wt_data, wt_ack=1; then IDLE.
REQ-023 mem_valid outside ISSUE/WAIT SHALL be ignored; after the 8th return, further mem_valid SHALL also be ignored.
REQ-024 A request deasserted mid-fill SHALL NOT abort the fill; the line still completes, along with its done pulse.
REQ-025 i_busy = i_req & ~i_done; d_busy = (d_req & ~d_done) | (wt_req & ~wt_ack).
REQ-026 mem_addr SHALL wrap modulo 2^16; with base 16'hFFF0 the last issue address SHALL be 16'hFFFE.
REQ-027 Outside ISSUE and WRITE, mem_en, mem_wr, mem_addr and mem_wdata SHALL be 0.
REQ-028 From request sampled in IDLE (cycle c0) to done pulse, latency SHALL be 9 + MEM_LATENCY cycles (13 at default).

Reset
REQ-029 rst_n=0 at a clock edge SHALL force IDLE and clear issue_cnt, ret_cnt, base, fill_sel and the starvation flag.
REQ-030 During and after reset, all registered outputs SHALL be 0 until the next grant.
REQ-031 Reset during ISSUE, WAIT or DONE SHALL abort the operation with no done pulse and no fill_tag_we.
REQ-032 Reset during WRITE SHALL suppress wt_ack after the edge.

Verification
REQ-033 Single I-fill: i_req=1, i_addr=16'h1234, memory model returns addr as data -> addresses 1230..123E issued over 8 consecutive cycles; fill_word 0..7 with data 1230..123E; fill_sel=0; i_done and fill_tag_we at c0+13.
REQ-034 Simultaneous i_req (0x0040), d_req (0x8000), wt_req (0x9002, data 0xBEEF) -> I-fill first, then the D-fill (starvation flag set), then WRITE with mem_wr=1, addr 9002, wdata BEEF and wt_ack.
REQ-035 Wrap: d_addr=16'hFFF6 -> issues FFF0..FFFE; d_done with fill_sel=1.
REQ-036 Reset asserted in cycle c0+6 of an I-fill -> no i_done, no fill_tag_we; mem_en=0 after the edge; a new i_req restarts at word 0.
REQ-037 Spurious mem_valid in IDLE, plus a 9th mem_valid after the 8th return -> no fill_we, and counters unchanged.
REQ-038 i_req dropped in cycle c0+3 -> fill still completes, with all 8 fill_we and i_done at c0+13.

Source files
------------

// File: rtl/cache_mem_arbiter.sv
// Shares one memory port between I-cache line fills, D-cache line fills and
// D-cache write-through stores.
//   clk, rst_n              : clock, synchronous active-low reset
//   i_req/i_addr            : I-cache miss request (held until i_done)
//   d_req/d_addr            : D-cache miss request (held until d_done)
//   wt_req/wt_addr/wt_data  : write-through store (held until wt_ack)
//   mem_en/mem_wr/mem_addr/mem_wdata, mem_valid/mem_rdata : memory port
//   fill_we/fill_sel/fill_word/fill_data, fill_tag_we     : line-fill writes
//   i_done/d_done/wt_ack    : completion pulses
//   i_busy/d_busy           : combinational pipeline stalls
module cache_mem_arbiter #(
  parameter int MEM_LATENCY = 4,
  parameter int LINE_WORDS  = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_req,
  input  logic [15:0] i_addr,
  input  logic        d_req,
  input  logic [15:0] d_addr,
  input  logic        wt_req,
  input  logic [15:0] wt_addr,
  input  logic [15:0] wt_data,
  output logic        mem_en,
  output logic        mem_wr,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic        mem_valid,
  input  logic [15:0] mem_rdata,
  output logic        fill_we,
  output logic        fill_sel,
  output logic [2:0]  fill_word,
  output logic [15:0] fill_data,
  output logic        fill_tag_we,
  output logic        i_done,
  output logic        d_done,
  output logic        wt_ack,
  output logic        i_busy,
  output logic        d_busy
);

  localparam int unsigned WW = 3;
  localparam logic [WW-1:0] LAST_WORD = WW'(LINE_WORDS - 1);
  localparam logic [15:0] LINE_MASK = 16'hFFF0;

  // This revision supports 8-word lines and a non-zero memory latency only.
  if (LINE_WORDS != 8 || MEM_LATENCY < 1) begin : g_param_check
    $error("cache_mem_arbiter: unsupported LINE_WORDS/MEM_LATENCY");
  end

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_WAIT  = 3'd2,
    S_DONE  = 3'd3,
    S_WRITE = 3'd4
  } state_e;

  state_e        state_q, state_d;
  logic [WW-1:0] issue_cnt_q, issue_cnt_d;
  logic [WW-1:0] ret_cnt_q, ret_cnt_d;
  logic [15:0]   base_q, base_d;
  logic          fill_sel_q, fill_sel_d;
  logic          starve_q, starve_d;

  logic          accept_c;
  logic          d_wins_c;

  // A return is only taken while a fill is outstanding; the state leaves
  // ISSUE/WAIT on the 8th return, so later returns fall outside the window.
  assign accept_c = mem_valid && (state_q == S_ISSUE || state_q == S_WAIT);

  // D wins outright if it was already waiting when the previous grant was made.
  assign d_wins_c = d_req && (starve_q || (!i_req && !wt_req));

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      issue_cnt_q <= '0;
      ret_cnt_q   <= '0;
      base_q      <= '0;
      fill_sel_q  <= 1'b0;
      starve_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      issue_cnt_q <= issue_cnt_d;
      ret_cnt_q   <= ret_cnt_d;
      base_q      <= base_d;
      fill_sel_q  <= fill_sel_d;
      starve_q    <= starve_d;
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_d     = state_q;
    issue_cnt_d = issue_cnt_q;
    ret_cnt_d   = ret_cnt_q;
    base_d      = base_q;
    fill_sel_d  = fill_sel_q;
    starve_d    = starve_q;

    unique case (state_q)
      S_IDLE: begin
        issue_cnt_d = '0;
        ret_cnt_d   = '0;
        if (d_wins_c) begin
          base_d     = d_addr & LINE_MASK;
          fill_sel_d = 1'b1;
          starve_d   = 1'b0;
          state_d    = S_ISSUE;
        end else if (i_req) begin
          base_d     = i_addr & LINE_MASK;
          fill_sel_d = 1'b0;
          starve_d   = d_req;
          state_d    = S_ISSUE;
        end else if (wt_req) begin
          starve_d   = d_req;
          state_d    = S_WRITE;
        end
      end
      S_ISSUE: begin
        issue_cnt_d = issue_cnt_q + WW'(1);
        if (issue_cnt_q == LAST_WORD) state_d = S_WAIT;
      end
      S_WAIT:  state_d = S_WAIT;
      S_DONE:  state_d = S_IDLE;
      S_WRITE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Returns can land in ISSUE (short latency) or WAIT; the last one ends the fill.
    if (accept_c) begin
      ret_cnt_d = ret_cnt_q + WW'(1);
      if (ret_cnt_q == LAST_WORD) state_d = S_DONE;
    end
  end

  // Output decode.
  always_comb begin
    mem_en      = 1'b0;
    mem_wr      = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;
    fill_we     = accept_c;
    fill_sel    = fill_sel_q;
    fill_word   = '0;
    fill_data   = '0;
    fill_tag_we = 1'b0;
    i_done      = 1'b0;
    d_done      = 1'b0;
    wt_ack      = 1'b0;

    if (accept_c) begin
      fill_word = ret_cnt_q;
      fill_data = mem_rdata;
    end

    unique case (state_q)
      S_ISSUE: begin
        mem_en   = 1'b1;
        mem_addr = 16'(base_q + 16'({issue_cnt_q, 1'b0}));
      end
      S_WRITE: begin
        mem_en    = 1'b1;
        mem_wr    = 1'b1;
        mem_addr  = wt_addr;
        mem_wdata = wt_data;
        wt_ack    = 1'b1;
      end
      S_DONE: begin
        fill_tag_we = 1'b1;
        i_done      = !fill_sel_q;
        d_done      = fill_sel_q;
      end
      default: ;
    endcase
  end

  assign i_busy = i_req & ~i_done;
  assign d_busy = (d_req & ~d_done) | (wt_req & ~wt_ack);

endmodule
